// File: rtl/sevenseg_scan_if.sv
// Bundle between the time datapath and the seven-segment scanner.
// The master supplies the digit values and attributes; the slave drives the display pins.
interface sevenseg_scan_if #(
  parameter int NUM_DIGITS = 4
);
  logic [4*NUM_DIGITS-1:0] digits;
  logic [NUM_DIGITS-1:0]   dots;
  logic [NUM_DIGITS-1:0]   blank;
  logic [NUM_DIGITS-1:0]   blink;
  logic                    lz_en;
  logic [0:6]              segments;
  logic                    dot_n;
  logic [NUM_DIGITS-1:0]   anode_active;
  logic                    frame_tick;

  modport master (
    output digits, dots, blank, blink, lz_en,
    input  segments, dot_n, anode_active, frame_tick
  );

  modport slave (
    input  digits, dots, blank, blink, lz_en,
    output segments, dot_n, anode_active, frame_tick
  );
endinterface

// File: rtl/sevenseg_scan.sv
// Self-scanning common-anode seven-segment driver with dead time, blink,
// blanking, leading-zero suppression and optional hex decode.
module sevenseg_scan #(
  parameter int NUM_DIGITS   = 4,
  parameter int SCAN_DIV     = 100000,
  parameter int DEAD_CYCLES  = 1000,
  parameter int BLINK_FRAMES = 128,
  parameter int HEX_EN       = 1
) (
  input logic            clk,
  input logic            reset,
  sevenseg_scan_if.slave bus
);

  localparam int IDX_W = $clog2(NUM_DIGITS);
  localparam int PW    = $clog2(SCAN_DIV);
  localparam int FW    = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [PW-1:0]    P_LAST = PW'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0] I_LAST = IDX_W'(NUM_DIGITS - 1);
  localparam logic [FW-1:0]    F_LAST = FW'(BLINK_FRAMES - 1);

  logic [PW-1:0]    presc;
  logic [IDX_W-1:0] idx;
  logic [FW-1:0]    fcnt;
  logic             hidden;
  logic             slot_end;
  logic             frame_end;

  logic [3:0]            cur_val;
  logic                  cur_dp;
  logic                  cur_blank;
  logic                  cur_blink;
  logic                  cur_zero;
  logic [NUM_DIGITS-1:0] zero_from;
  logic                  zacc;
  logic                  in_dead;
  logic                  suppress;
  logic                  dark;

  logic [0:6]            seg_p0;
  logic                  dot_p0;
  logic [NUM_DIGITS-1:0] anode_p0;

  function automatic logic [0:6] decode(input logic [3:0] v);
    logic [0:6] s;
    case (v)
      4'h0:    s = 7'b0000001;
      4'h1:    s = 7'b1001111;
      4'h2:    s = 7'b0010010;
      4'h3:    s = 7'b0000110;
      4'h4:    s = 7'b1001100;
      4'h5:    s = 7'b0100100;
      4'h6:    s = 7'b0100000;
      4'h7:    s = 7'b0001111;
      4'h8:    s = 7'b0000000;
      4'h9:    s = 7'b0000100;
      4'hA:    s = 7'b0001000;
      4'hB:    s = 7'b1100000;
      4'hC:    s = 7'b0110001;
      4'hD:    s = 7'b1000010;
      4'hE:    s = 7'b0110000;
      default: s = 7'b0111000;
    endcase
    if (HEX_EN == 0 && v > 4'd9) s = 7'b1111111;
    return s;
  endfunction

  assign slot_end  = (presc == P_LAST);
  assign frame_end = slot_end && (idx == I_LAST);

  // Stage p0: scan counters (prescaler, digit index, frame/blink)
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc  <= '0;
      idx    <= '0;
      fcnt   <= '0;
      hidden <= 1'b0;
    end else begin
      presc <= slot_end ? '0 : presc + 1'b1;
      if (slot_end) idx <= (idx == I_LAST) ? '0 : idx + 1'b1;
      if (frame_end) begin
        if (fcnt == F_LAST) begin
          fcnt   <= '0;
          hidden <= ~hidden;
        end else begin
          fcnt <= fcnt + 1'b1;
        end
      end
    end
  end

  // zero_from[i] is set when digit i and every digit above it are zero.
  always_comb begin
    zero_from = '0;
    zacc      = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zacc         = zacc & (bus.digits[4*i +: 4] == 4'd0);
      zero_from[i] = zacc;
    end
  end

  always_comb begin
    cur_val   = '0;
    cur_dp    = 1'b0;
    cur_blank = 1'b0;
    cur_blink = 1'b0;
    cur_zero  = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx == IDX_W'(i)) begin
        cur_val   = bus.digits[4*i +: 4];
        cur_dp    = bus.dots[i];
        cur_blank = bus.blank[i];
        cur_blink = bus.blink[i];
        cur_zero  = zero_from[i];
      end
    end
  end

  // A suppressed leading zero with its dot set keeps the anode on to show the dot.
  always_comb begin
    in_dead  = (int'(presc) < DEAD_CYCLES);
    suppress = bus.lz_en && (idx != '0) && cur_zero;
    dark     = in_dead | cur_blank | (cur_blink & hidden) | (suppress & ~cur_dp);
    anode_p0 = dark ? '1 : ~(NUM_DIGITS'(1) << idx);
    seg_p0   = (dark | suppress) ? 7'b1111111 : decode(cur_val);
    dot_p0   = dark | ~cur_dp;
  end

  // Stage p1: registered display pins
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.segments     <= 7'b1111111;
      bus.dot_n        <= 1'b1;
      bus.anode_active <= '1;
      bus.frame_tick   <= 1'b0;
    end else begin
      bus.segments     <= seg_p0;
      bus.dot_n        <= dot_p0;
      bus.anode_active <= anode_p0;
      bus.frame_tick   <= frame_end;
    end
  end

endmodule

// File: doc/sevenseg_scan.md
Name: sevenseg_scan

Overview:
- Self-scanning, time-multiplexed driver for a common-anode seven-segment display with NUM_DIGITS digits.
- Owns the refresh prescaler and digit-select counter; callers supply only packed BCD/hex values and per-digit attributes.
- Adds per-digit decimal points, blanking, blinking, leading-zero suppression, hex decode and anti-ghosting dead time.
- Sits between the clock/alarm time datapath and the board display pins.

Parameters:
- NUM_DIGITS, 4, number of multiplexed digits (2..8).
- SCAN_DIV, 100000, clock cycles per digit slot (>= 2).
- DEAD_CYCLES, 1000, cycles at the start of each slot with all anodes off (0 <= DEAD_CYCLES < SCAN_DIV).
- BLINK_FRAMES, 128, full scan frames per blink half-period (>= 1).
- HEX_EN, 1, 1 = codes 10..15 shown as A,b,C,d,E,F; 0 = codes 10..15 shown blank.

Ports:
- clk, input, 1, system clock.
- reset, input, 1, asynchronous, active-high.
- digits, input, 4*NUM_DIGITS, digit i value at [4i+3:4i]; digit 0 is rightmost.
- dots, input, NUM_DIGITS, 1 = light the decimal point of digit i.
- blank, input, NUM_DIGITS, 1 = digit i is always off.
- blink, input, NUM_DIGITS, 1 = digit i blinks.
- lz_en, input, 1, 1 = leading-zero suppression enabled.
- segments, output, [0:6], segments a..g, active-low, registered.
- dot_n, output, 1, decimal point, active-low, registered.
- anode_active, output, NUM_DIGITS, active-low digit enables, registered; bit i drives digit i.
- frame_tick, output, 1, one-cycle pulse when the scan wraps from digit NUM_DIGITS-1 to digit 0.

Behaviour:
- Reset state (asynchronous; all items take these values immediately):
  - prescaler = 0, idx = 0, frame counter = 0, blink phase = visible.
  - segments = 7'b1111111, dot_n = 1, anode_active = all ones, frame_tick = 0.
- Prescaler:
  - Counts 0..SCAN_DIV-1 and wraps.
  - At the terminal count, idx advances: idx+1, or 0 when idx = NUM_DIGITS-1.
- frame_tick:
  - Asserted for the one cycle in which idx wraps to 0.
  - The frame counter increments on each frame_tick and runs 0..BLINK_FRAMES-1.
  - At the terminal frame count it wraps and blink phase toggles.
- Output timing: all outputs are registered from the current prescaler/idx, so they lag those counters by exactly one clock.
- Digit i is off (anode bit 1, segments all 1, dot_n 1) if any of the following holds:
  - the prescaler is < DEAD_CYCLES;
  - blank[i] = 1;
  - blink[i] = 1 and blink phase = hidden;
  - digit i is suppressed as a leading zero (below).
- Otherwise digit i is on: only anode bit i is 0, segments = decode(value i), dot_n = ~dots[i].
- At most one anode bit is low at any time.
- Leading-zero suppression (lz_en = 1):
  - Digit i > 0 is suppressed when its value and every higher digit's value are 0.
  - Digit 0 is never suppressed.
  - A suppressed digit whose dots bit is 1 still shows its dot (anode on, segments all 1).
- Decode table, segments[0:6] = a..g, active-low:
  - 0 = 0000001, 1 = 1001111, 2 = 0010010, 3 = 0000110, 4 = 1001100
  - 5 = 0100100, 6 = 0100000, 7 = 0001111, 8 = 0000000, 9 = 0000100
  - A = 0001000, b = 1100000, C = 0110001, d = 1000010, E = 0110000, F = 0111000
  - With HEX_EN = 0, codes 10..15 decode to 1111111.
  - The decoder is fully specified, with no latches.
- Input changes to digits, dots, blank, blink or lz_en take effect on the next clock; there is no need to wait for a slot boundary.
- Reset asserted mid-slot forces the reset values asynchronously. After release, scanning restarts at digit 0, prescaler 0, with the dead time applied.

Test Plan:
1. Reset and first slot (SCAN_DIV=4, DEAD_CYCLES=1, NUM_DIGITS=4), digits=16'h1234, dots=0. Assert reset mid-run.
   - During reset, anode_active = 1111 and segments = 1111111.
   - After release, the anode sequence per slot is 1111 then 1110 ×3 with segments = 1001100 ('4').
   - Following slots show digits 1, 2 and 3 on anodes 1101, 1011 and 0111 respectively.
2. Frame wrap: same setup.
   - frame_tick pulses once every 16 cycles, in the cycle idx goes 3 -> 0.
   - anode_active is never low on more than one bit; check every cycle.
3. Hex decode, digits=16'hFA0C.
   - HEX_EN=1: segments for digits 0..3 are 0110001, 0000001, 0001000, 0111000.
   - HEX_EN=0: digits 0, 2 and 3 are 1111111; digit 1 shows 0000001.
4. Leading zeros, digits=16'h0005, dots=4'b0100, lz_en=1.
   - Digits 3 and 1 keep their anode at 1.
   - Digit 2 has its anode on, segments = 1111111 and dot_n = 0.
   - Digit 0 shows 0100100.
   - Input 16'h0000 -> only digit 0 is lit, showing 0000001.
5. Blink (BLINK_FRAMES=2), blink=4'b0001.
   - Digit 0 is lit for 2 frames, dark for 2 frames, and repeats.
   - Digits 1..3 are unaffected.
   - blank=4'b0010 keeps digit 1 dark in every frame.
